elink_tx_arbiter: RTL and testbench

Parametrised N-channel transmit arbiter for the e-link 10b symbol path. It sits between the per-channel frame sources and the e-link serializer. It grants one channel at a time and holds the grant for the whole frame, which gives frame-atomic output. It inserts comma symbols whenever no data is transferred, enforces a minimum inter-frame gap, and guards against stuck frames with a length timeout. Arbitration is fixed-priority or round-robin.

---
 rtl/elink_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_elink_tx_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/elink_tx_arbiter.sv
// elink_tx_arbiter: N-channel transmit arbiter for the e-link 10b symbol path.
// It grants one source at a time and holds the grant for a whole frame, so
// frames reach the serializer without interleaving. Comma symbols fill every
// cycle without a transfer. A minimum gap follows each frame, and a length
// timeout releases frames whose last word never arrives.
module elink_tx_arbiter #(
    parameter int         N_CH      = 3,
    parameter int         DW        = 10,
    parameter logic [7:0] KCHAR     = 8'hBC,
    parameter int         RR_MODE   = 1,
    parameter int         MIN_GAP   = 1,
    parameter int         MAX_FRAME = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   ch_data_in,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [N_CH-1:0]      ch_last,
    output logic [N_CH-1:0]      ch_ready,
    output logic [DW-1:0]        data_tra_out,
    output logic [N_CH-1:0]      grant_oh,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IW       = $clog2(N_CH);
    localparam int CW       = $clog2(MAX_FRAME);
    localparam int GAP_LAST = (MIN_GAP > 0) ? (MIN_GAP - 1) : 0;

    // Comma word: upper bits all ones, K-character in the low byte.
    localparam logic [DW-1:0] COMMA = ({DW{1'b1}} << 8) | DW'(KCHAR);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [N_CH-1:0] grant_q,    grant_d;
    logic [IW-1:0]   win_q,      win_d;
    logic [IW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [3:0]      gap_cnt_q,  gap_cnt_d;
    logic [DW-1:0]   data_q,     data_d;
    logic            busy_q,     busy_d;
    logic            timeout_q,  timeout_d;

    logic [DW-1:0]   ch_word [N_CH];
    logic            arb_found;
    logic [IW-1:0]   arb_pick;
    logic [IW-1:0]   arb_idx;
    int              arb_sum;
    logic            frame_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign ch_word[g] = ch_data_in[g*DW +: DW];
    end

    // Pick the winner: search starts at rr_ptr in round-robin mode, at 0 otherwise.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = '0;
        arb_sum   = 0;
        for (int k = 0; k < N_CH; k++) begin
            arb_sum = ((RR_MODE != 0) ? int'(rr_ptr_q) : 0) + k;
            if (arb_sum >= N_CH) begin
                arb_sum = arb_sum - N_CH;
            end
            arb_idx = IW'(arb_sum);
            if (!arb_found && ch_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx;
            end
        end
    end

    // Frame FSM: grant in IDLE, stream or bubble in SEND, pad commas in GAP.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        win_d      = win_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = COMMA;
        timeout_d  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d    = N_CH'(1) << arb_pick;
                    win_d      = arb_pick;
                    word_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (ch_req[win_q]) begin
                    data_d = ch_word[win_q];
                end
                if (ch_req[win_q] && ch_last[win_q]) begin
                    frame_done = 1'b1;
                end else if (word_cnt_q == CW'(MAX_FRAME - 1)) begin
                    frame_done = 1'b1;
                    timeout_d  = 1'b1;
                end
                if (frame_done) begin
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (win_q == IW'(N_CH - 1)) ? '0 : win_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared to the idle/comma state on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            win_q      <= '0;
            rr_ptr_q   <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= COMMA;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            win_q      <= win_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ch_ready     = (state_q == ST_SEND) ? grant_q : '0;
    assign data_tra_out = data_q;
    assign grant_oh     = grant_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// tb_elink_tx_arbiter: directed bench for elink_tx_arbiter. Two instances share
// the same inputs: one round-robin, one fixed-priority, both with a short
// frame timeout so the forced-release path is reachable.
module tb_elink_tx_arbiter;

    localparam logic [9:0] COMMA = 10'h3BC;

    logic        clk;
    logic        rst;
    logic [29:0] ch_data_in;
    logic [2:0]  ch_req;
    logic [2:0]  ch_last;

    logic [2:0]  rr_ready, fp_ready;
    logic [9:0]  rr_data, fp_data;
    logic [2:0]  rr_grant, fp_grant;
    logic        rr_busy, fp_busy;
    logic        rr_to, fp_to;

    int checks = 0;
    int errors = 0;

    logic [2:0] rrOrder [4];
    logic [9:0] rrWord  [4];

    elink_tx_arbiter #(
        .N_CH(3), .DW(10), .KCHAR(8'hBC), .RR_MODE(1), .MIN_GAP(1), .MAX_FRAME(4)
    ) u_rr (
        .clk(clk), .rst(rst), .ch_data_in(ch_data_in), .ch_req(ch_req),
        .ch_last(ch_last), .ch_ready(rr_ready), .data_tra_out(rr_data),
        .grant_oh(rr_grant), .busy(rr_busy), .timeout_err(rr_to)
    );

    elink_tx_arbiter #(
        .N_CH(3), .DW(10), .KCHAR(8'hBC), .RR_MODE(0), .MIN_GAP(1), .MAX_FRAME(4)
    ) u_fp (
        .clk(clk), .rst(rst), .ch_data_in(ch_data_in), .ch_req(ch_req),
        .ch_last(ch_last), .ch_ready(fp_ready), .data_tra_out(fp_data),
        .grant_oh(fp_grant), .busy(fp_busy), .timeout_err(fp_to)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int inst, input logic [9:0] expData,
                               input logic [2:0] expGrant, input logic [2:0] expReady,
                               input logic expBusy, input logic expTo);
        if (inst == 0) begin
            checkVal({tag, ".rr.data"},  16'(rr_data),  16'(expData));
            checkVal({tag, ".rr.grant"}, 16'(rr_grant), 16'(expGrant));
            checkVal({tag, ".rr.ready"}, 16'(rr_ready), 16'(expReady));
            checkVal({tag, ".rr.busy"},  16'(rr_busy),  16'(expBusy));
            checkVal({tag, ".rr.tout"},  16'(rr_to),    16'(expTo));
        end else begin
            checkVal({tag, ".fp.data"},  16'(fp_data),  16'(expData));
            checkVal({tag, ".fp.grant"}, 16'(fp_grant), 16'(expGrant));
            checkVal({tag, ".fp.ready"}, 16'(fp_ready), 16'(expReady));
            checkVal({tag, ".fp.busy"},  16'(fp_busy),  16'(expBusy));
            checkVal({tag, ".fp.tout"},  16'(fp_to),    16'(expTo));
        end
    endtask

    task automatic checkBoth(input string tag, input logic [9:0] expData, input logic [2:0] expGrant,
                             input logic [2:0] expReady, input logic expBusy, input logic expTo);
        checkOutput(tag, 0, expData, expGrant, expReady, expBusy, expTo);
        checkOutput(tag, 1, expData, expGrant, expReady, expBusy, expTo);
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] last,
                                 input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2);
        ch_req     = req;
        ch_last    = last;
        ch_data_in = {d2, d1, d0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; each window opens 1 time unit after a rising edge.
    initial begin
        rrOrder = '{3'b001, 3'b010, 3'b100, 3'b001};
        rrWord  = '{10'h100, 10'h111, 10'h122, 10'h100};

        rst = 1'b1;
        applyStimulus(3'b000, 3'b000, 10'h000, 10'h000, 10'h000);
        #12;
        checkBoth("reset", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] idle commas");
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkBoth("idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);
        end

        $display("[TB] channel 1 three-word frame");
        applyStimulus(3'b010, 3'b000, 10'h3FF, 10'h155, 10'h3FF);
        nextCycle();
        checkBoth("f1.w0", COMMA, 3'b010, 3'b010, 1'b1, 1'b0);
        nextCycle();
        checkBoth("f1.w1", 10'h155, 3'b010, 3'b010, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b000, 10'h3FF, 10'h0AA, 10'h3FF);
        nextCycle();
        checkBoth("f1.w2", 10'h0AA, 3'b010, 3'b010, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b010, 10'h3FF, 10'h2F0, 10'h3FF);
        nextCycle();
        checkBoth("f1.gap", 10'h2F0, 3'b000, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("f1.idle0", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);
        nextCycle();
        checkBoth("f1.idle1", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] all channels, two-word frames");
        rst = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(3'b111, 3'b000, 10'h100, 10'h111, 10'h122);
        for (int f = 0; f < 4; f++) begin
            nextCycle();
            checkOutput("arb.s1", 0, COMMA, rrOrder[f], rrOrder[f], 1'b1, 1'b0);
            checkOutput("arb.s1", 1, COMMA, 3'b001, 3'b001, 1'b1, 1'b0);
            nextCycle();
            checkOutput("arb.s2", 0, rrWord[f], rrOrder[f], rrOrder[f], 1'b1, 1'b0);
            checkOutput("arb.s2", 1, 10'h100, 3'b001, 3'b001, 1'b1, 1'b0);
            applyStimulus(3'b111, 3'b111, 10'h100, 10'h111, 10'h122);
            nextCycle();
            checkOutput("arb.gap", 0, rrWord[f], 3'b000, 3'b000, 1'b1, 1'b0);
            checkOutput("arb.gap", 1, 10'h100, 3'b000, 3'b000, 1'b1, 1'b0);
            applyStimulus((f == 3) ? 3'b000 : 3'b111, 3'b000, 10'h100, 10'h111, 10'h122);
            nextCycle();
            checkBoth("arb.idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);
        end

        $display("[TB] timeout on channel 2");
        applyStimulus(3'b100, 3'b000, 10'h3FF, 10'h3FF, 10'h1C2);
        nextCycle();
        checkBoth("to.c0", COMMA, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        checkBoth("to.c1", 10'h1C2, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        checkBoth("to.c2", 10'h1C2, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        checkBoth("to.c3", 10'h1C2, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        checkBoth("to.gap", 10'h1C2, 3'b000, 3'b000, 1'b1, 1'b1);
        applyStimulus(3'b000, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("to.idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] last on word four beats timeout");
        applyStimulus(3'b100, 3'b000, 10'h3FF, 10'h3FF, 10'h2C4);
        nextCycle();
        checkBoth("lw.c0", COMMA, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        checkBoth("lw.c2", 10'h2C4, 3'b100, 3'b100, 1'b1, 1'b0);
        nextCycle();
        checkBoth("lw.c3", 10'h2C4, 3'b100, 3'b100, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b100, 10'h3FF, 10'h3FF, 10'h2C4);
        nextCycle();
        checkBoth("lw.gap", 10'h2C4, 3'b000, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("lw.idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(3'b001, 3'b000, 10'h0F1, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("mr.w0", COMMA, 3'b001, 3'b001, 1'b1, 1'b0);
        nextCycle();
        checkBoth("mr.w1", 10'h0F1, 3'b001, 3'b001, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkBoth("mr.rst", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        applyStimulus(3'b000, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("mr.idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] two-cycle request bubble");
        applyStimulus(3'b010, 3'b000, 10'h3FF, 10'h2A5, 10'h3FF);
        nextCycle();
        checkBoth("bb.s0", COMMA, 3'b010, 3'b010, 1'b1, 1'b0);
        nextCycle();
        checkBoth("bb.s1", 10'h2A5, 3'b010, 3'b010, 1'b1, 1'b0);
        applyStimulus(3'b001, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("bb.b1", COMMA, 3'b010, 3'b010, 1'b1, 1'b0);
        applyStimulus(3'b001, 3'b010, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("bb.b2", COMMA, 3'b010, 3'b010, 1'b1, 1'b0);
        applyStimulus(3'b011, 3'b010, 10'h3FF, 10'h35A, 10'h3FF);
        nextCycle();
        checkBoth("bb.gap", 10'h35A, 3'b000, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
        nextCycle();
        checkBoth("bb.idle", COMMA, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
